cnt_cmd_seq: RTL

CNT_CMD_SEQ -- requirements
Module: cnt_cmd_seq

---
 rtl/cnt_cmd_pkg.sv | 14 +
 rtl/cnt_cmd_seq_if.sv | 26 ++
 rtl/cnt_cmd_down.sv | 31 +++
 rtl/cnt_cmd_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/cnt_cmd_pkg.sv
// cnt_cmd_pkg: shared types and constants for the counter command sequencer.
// Holds the FSM state encoding and the command opcode values.
package cnt_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_RUN  = 1'b1;

endpackage

// File: rtl/cnt_cmd_seq_if.sv
// cnt_cmd_seq_if: valid/ready command channel into the sequencer.
// The master offers op/arg with valid; the slave answers with ready.
interface cnt_cmd_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/cnt_cmd_down.sv
// cnt_cmd_down: loadable down-counter tracking the RUN steps still to issue.
// 'last' flags the final step so the sequencer can finish without wrapping.
module cnt_cmd_down #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  // Clear wins over load, load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/cnt_cmd_seq.sv
// cnt_cmd_seq: accepts LOAD/RUN commands and drives a downstream counter's
// write enable / count enable. All outputs except cmd_ready are registered.
// Optional abort feature: define CNT_CMD_SEQ_ABORT_EN to add abort/aborted.
module cnt_cmd_seq
  import cnt_cmd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  cnt_cmd_seq_if.slave     cmd,
  output logic             cen,
  output logic             wen,
  output logic [WIDTH-1:0] dat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
`ifdef CNT_CMD_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_t state;
  logic   accept;
  logic   abort_hit;
  logic   run_last;

  assign cmd.cmd_ready = (state == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef CNT_CMD_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  cnt_cmd_down #(
    .WIDTH(WIDTH)
  ) u_down (
    .clk   (clk),
    .rst   (rst),
    .load  (accept && (cmd.cmd_op == OP_RUN)),
    .dec   (state == RUN),
    .clr   (abort_hit),
    .val   (cmd.cmd_arg),
    .count (remaining),
    .last  (run_last)
  );

  // Command FSM with registered enables, data and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cen   <= 1'b0;
      wen   <= 1'b0;
      dat   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
`ifdef CNT_CMD_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      wen  <= 1'b0;
`ifdef CNT_CMD_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      if (abort_hit) begin
        state <= IDLE;
        cen   <= 1'b0;
        busy  <= 1'b0;
`ifdef CNT_CMD_SEQ_ABORT_EN
        aborted <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (cmd.cmd_op == OP_LOAD) begin
                state <= LOAD;
                wen   <= 1'b1;
                dat   <= cmd.cmd_arg;
                busy  <= 1'b1;
              end else if (cmd.cmd_arg != '0) begin
                state <= RUN;
                cen   <= 1'b1;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          LOAD: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          RUN: begin
            if (run_last) begin
              state <= IDLE;
              cen   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cen   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
